// File: rtl/alarm_bank_editor.sv
// Bank of NUM_ALARMS BCD HH:MM:SS alarms: browse/edit on the shared button bus,
// edits held in a working copy until committed, display drive and hit pulses.
module alarm_bank_editor #(
    parameter int NUM_ALARMS   = 3,
    parameter int ACTIVE_STATE = 2,
    parameter int IDX_W        = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [3:0]                totalstate,
    input  logic [3:0]                up_button,
    input  logic [3:0]                down_button,
    input  logic [3:0]                left_button,
    input  logic [3:0]                right_button,
    input  logic [3:0]                enter_button,
    input  logic [3:0]                return_button,
    input  logic [23:0]               cur_time,
    input  logic                      sec_tick,
    output logic [3:0]                led1Number,
    output logic [3:0]                led2Number,
    output logic [3:0]                led3Number,
    output logic [3:0]                led4Number,
    output logic [3:0]                led5Number,
    output logic [3:0]                led6Number,
    output logic [3:0]                led7Number,
    output logic [3:0]                led8Number,
    output logic [7:0]                point,
    output logic [7:0]                which_shine,
    output logic                      is_shine,
    output logic [24*NUM_ALARMS-1:0]  alarm_time,
    output logic [NUM_ALARMS-1:0]     alarm_enable,
    output logic [NUM_ALARMS-1:0]     alarm_hit,
    output logic [IDX_W-1:0]          cur_index
);

    typedef enum logic {SHOW, EDIT} state_e;
    typedef enum logic [2:0] {B_NONE, B_RET, B_ENT, B_UP, B_DN, B_LEFT, B_RIGHT} btn_e;

    state_e               state;
    logic [2:0]           pos;
    logic [23:0]          work;
    logic                 press_lock;

    logic                 active;
    logic                 all_idle;
    btn_e                 btn;
    logic [3:0]           code;
    logic [23:0]          slot_time;
    logic                 slot_en;
    logic [3:0]           dig;
    logic [3:0]           dig_max;
    logic [3:0]           dig_up;
    logic [3:0]           dig_dn;
    logic [NUM_ALARMS-1:0] hit_next;
    logic [23:0]          shown;

    // Writes one working digit; raising hr hi to 2 pulls an out-of-range hr lo down to 3.
    function automatic logic [23:0] put_digit(input logic [23:0] w, input logic [2:0] p,
                                              input logic [3:0] v);
        logic [23:0] r;
        r = w;
        for (int unsigned k = 0; k < 6; k++) begin
            if (p == 3'(k)) r[4*k +: 4] = v;
        end
        if (p == 3'd5 && v == 4'd2 && r[19:16] > 4'd3) r[19:16] = 4'd3;
        return r;
    endfunction

    assign active   = (totalstate == 4'(ACTIVE_STATE));
    assign all_idle = ~|{up_button, down_button, left_button, right_button,
                         enter_button, return_button};

    always_comb begin
        btn  = B_NONE;
        code = 4'd0;
        if (return_button != 4'd0) begin
            btn  = B_RET;
            code = return_button;
        end else if (enter_button != 4'd0) begin
            btn  = B_ENT;
            code = enter_button;
        end else if (up_button != 4'd0) begin
            btn  = B_UP;
            code = up_button;
        end else if (down_button != 4'd0) begin
            btn  = B_DN;
            code = down_button;
        end else if (left_button != 4'd0) begin
            btn  = B_LEFT;
            code = left_button;
        end else if (right_button != 4'd0) begin
            btn  = B_RIGHT;
            code = right_button;
        end
    end

    always_comb begin
        slot_time = '0;
        slot_en   = 1'b0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (cur_index == IDX_W'(i)) begin
                slot_time = alarm_time[24*i +: 24];
                slot_en   = alarm_enable[i];
            end
        end
    end

    always_comb begin
        dig = 4'd0;
        for (int unsigned k = 0; k < 6; k++) begin
            if (pos == 3'(k)) dig = work[4*k +: 4];
        end
        case (pos)
            3'd0, 3'd2: dig_max = 4'd9;
            3'd1, 3'd3: dig_max = 4'd5;
            3'd4:       dig_max = (work[23:20] < 4'd2) ? 4'd9 : 4'd3;
            3'd5:       dig_max = 4'd2;
            default:    dig_max = 4'd0;
        endcase
        dig_up = (dig >= dig_max) ? 4'd0 : dig + 4'd1;
        dig_dn = (dig == 4'd0) ? dig_max : dig - 4'd1;
    end

    // Hit compares the committed value and enable as they stand before this edge's commit.
    always_comb begin
        hit_next = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            hit_next[i] = sec_tick && alarm_enable[i] && (alarm_time[24*i +: 24] == cur_time);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= SHOW;
            pos          <= '0;
            work         <= '0;
            press_lock   <= 1'b0;
            alarm_time   <= '0;
            alarm_enable <= '0;
            alarm_hit    <= '0;
            cur_index    <= '0;
        end else begin
            alarm_hit <= hit_next;
            if (all_idle) press_lock <= 1'b0;
            if (!active) begin
                state <= SHOW;
                work  <= '0;
                pos   <= '0;
            end else if (!press_lock && btn != B_NONE) begin
                press_lock <= 1'b1;
                if (state == SHOW) begin
                    case (btn)
                        B_LEFT:  cur_index <= (cur_index == '0) ? IDX_W'(NUM_ALARMS-1)
                                                                : cur_index - IDX_W'(1);
                        B_RIGHT: cur_index <= (cur_index == IDX_W'(NUM_ALARMS-1)) ? '0
                                                                : cur_index + IDX_W'(1);
                        B_ENT: begin
                            if (code == 4'd1) begin
                                for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                                    if (cur_index == IDX_W'(i)) alarm_enable[i] <= ~alarm_enable[i];
                                end
                            end else if (code == 4'd2) begin
                                work  <= slot_time;
                                pos   <= '0;
                                state <= EDIT;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    case (btn)
                        B_LEFT:  pos  <= (pos == 3'd5) ? 3'd0 : pos + 3'd1;
                        B_RIGHT: pos  <= (pos == 3'd0) ? 3'd5 : pos - 3'd1;
                        B_UP:    work <= put_digit(work, pos, dig_up);
                        B_DN:    work <= put_digit(work, pos, dig_dn);
                        B_ENT: begin
                            if (code == 4'd1) begin
                                for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                                    if (cur_index == IDX_W'(i)) begin
                                        alarm_time[24*i +: 24] <= work;
                                        alarm_enable[i]        <= 1'b1;
                                    end
                                end
                                work  <= '0;
                                state <= SHOW;
                            end
                        end
                        B_RET: begin
                            if (code == 4'd1) begin
                                work  <= '0;
                                state <= SHOW;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        shown       = (state == EDIT) ? work : slot_time;
        led1Number  = shown[3:0];
        led2Number  = shown[7:4];
        led3Number  = 4'hA;
        led4Number  = shown[11:8];
        led5Number  = shown[15:12];
        led6Number  = 4'hA;
        led7Number  = shown[19:16];
        led8Number  = shown[23:20];
        point       = {7'h7F, ~slot_en};
        is_shine    = (state == EDIT);
        which_shine = 8'h00;
        if (state == EDIT) begin
            case (pos)
                3'd0:    which_shine = 8'h01;
                3'd1:    which_shine = 8'h02;
                3'd2:    which_shine = 8'h08;
                3'd3:    which_shine = 8'h10;
                3'd4:    which_shine = 8'h40;
                3'd5:    which_shine = 8'h80;
                default: which_shine = 8'h00;
            endcase
        end
    end

endmodule

// File: doc/alarm_bank_editor.md
Name: alarm_bank_editor

Overview:
- Parametrised bank of NUM_ALARMS HH:MM:SS alarms in BCD, with per-alarm enable.
- Browse and edit run from the shared button bus while totalstate == ACTIVE_STATE.
- Edits go to a working copy: commit on enter, discard on return.
- Compares committed, enabled alarms against the running clock and pulses a per-alarm hit. It feeds the 8-digit display mux and the buzzer/ring controller.

Parameters:
- NUM_ALARMS, 3, number of alarm slots (1..8).
- ACTIVE_STATE, 2, totalstate value in which this block owns the buttons and display.
- IDX_W, 3, width of the alarm index (must hold NUM_ALARMS-1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- totalstate  in  4  top-level mode; block is active only when == ACTIVE_STATE
- up_button, down_button, left_button, right_button, enter_button, return_button  in  4 each  button code: 0 none, 1 short press, 2 long press
- cur_time  in  24  running clock {hh,mm,ss} BCD
- sec_tick  in  1  one-cycle pulse when cur_time has just advanced
- led1Number..led8Number  out  4 each  display digits, led1 = seconds low
- point  out  8  decimal points, active-low
- which_shine  out  8  one-hot blinking digit
- is_shine  out  1  blink enable
- alarm_time  out  24*NUM_ALARMS  committed alarms; slot i at [24i+23:24i] as {hh,mm,ss}
- alarm_enable  out  NUM_ALARMS  per-slot enable
- alarm_hit  out  NUM_ALARMS  one-cycle hit pulse per slot
- cur_index  out  IDX_W  slot currently shown

Behaviour:
- Reset values (reset_n low at a clk edge):
  - all alarm_time 0, alarm_enable 0, alarm_hit 0, cur_index 0;
  - state SHOW, pos 0, working copy 0, press_lock 0;
  - is_shine 0, which_shine 0, point 8'hFF.
- press_lock:
  - an action is taken only when press_lock == 0 and a code is nonzero;
  - taking an action sets press_lock;
  - press_lock clears the cycle after all six button inputs read 0;
  - one action per physical press.
- Simultaneous buttons: only the highest-priority button acts, in the order return, enter, up, down, left, right.
- SHOW state, each press:
  - left: cur_index decrements, wrapping 0 -> NUM_ALARMS-1.
  - right: cur_index increments, wrapping NUM_ALARMS-1 -> 0.
  - enter=1: toggles alarm_enable[cur_index].
  - enter=2: copies slot cur_index into the working copy, sets pos=0, goes to EDIT.
  - Display shows the committed slot.
- EDIT state:
  - Digit positions: pos 0..5 = sec lo, sec hi, min lo, min hi, hr lo, hr hi.
  - left: pos+1, wrapping 5 -> 0. right: pos-1, wrapping 0 -> 5.
  - up/down modify the selected working digit modulo its range:
    - sec and min low: 0-9; sec and min high: 0-5;
    - hr hi: 0-2;
    - hr lo: 0-9 when hr hi < 2, else 0-3.
    - Down from 0 wraps to the range max.
  - If hr hi becomes 2 while hr lo > 3, hr lo is forced to 3 in the same cycle.
  - enter=1: writes the working copy to slot cur_index, sets that slot's enable to 1, returns to SHOW.
  - return=1: discards the working copy, returns to SHOW.
  - Display shows the working copy.
- Display:
  - led3 = led6 = 4'hA (dash);
  - point[0] = ~alarm_enable[cur_index], other bits 1;
  - is_shine = 1 only in EDIT;
  - which_shine one-hot by pos: 0 -> 8'h01, 1 -> 8'h02, 2 -> 8'h08, 3 -> 8'h10, 4 -> 8'h40, 5 -> 8'h80;
  - which_shine is 0 in SHOW.
- totalstate != ACTIVE_STATE:
  - buttons are ignored;
  - an active EDIT is abandoned (state SHOW, working copy discarded);
  - committed slots and hit logic keep running.
- Hit logic:
  - On a sec_tick cycle, each slot i with alarm_enable[i] == 1 and committed time == cur_time has alarm_hit[i] set for exactly the next cycle.
  - All matching slots pulse together.
  - No pulse without sec_tick.
  - Editing a slot never affects its hit until committed; a commit landing on the sec_tick cycle compares the old value.
- Reset mid-edit: everything returns to reset values; no commit occurs.

Test Plan:
- Reset, then totalstate=2, right=1 pressed NUM_ALARMS times -> cur_index cycles 0,1,2,0. Holding right 5 cycles -> single increment only.
- From 0, left=1 -> cur_index = 2 (NUM_ALARMS=3).
- Edit and commit, slot 0:
  - enter=2, then up at pos 5 twice -> working hr hi = 2.
  - right to pos 4, up x5 -> hr lo sequence 1,2,3,0,1.
  - enter=1 -> alarm_time[23:0] = 24'h210000, alarm_enable[0] = 1, is_shine = 0.
- Hour-low clamp: working hr = 19, set hr hi to 2 -> hr = 23.
- Cancel: edit slot 1 to 12:34:56, return=1 -> alarm_time[47:24] stays 0. Likewise totalstate changed to 0 mid-edit -> EDIT exits, no commit.
- Hits:
  - slots 0 and 2 both 07:30:00 and enabled, cur_time = 24'h073000 with sec_tick -> alarm_hit = 3'b101 for one cycle, then 0.
  - Slot 2 disabled via enter=1 -> next match gives 3'b001.
